// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB ports
// and returns CSR results; owns the search-port-1 mux shared with load/store.
module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [4:0]      req_inv_op,
   input  logic [IDXW-1:0] req_index,
   input  logic [18:0]     req_vppn,
   input  logic [9:0]      req_asid,
   input  logic [88:0]     req_entry,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_found,
   output logic [IDXW-1:0] resp_index,
   output logic [88:0]     resp_entry,
   output logic            resp_err,
   input  logic [18:0]     mem_s1_vppn,
   input  logic [9:0]      mem_s1_asid,
   output logic            mem_stall,
   output logic [18:0]     tlb_s1_vppn,
   output logic [9:0]      tlb_s1_asid,
   input  logic            tlb_s1_found,
   input  logic [IDXW-1:0] tlb_s1_index,
   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index,
   output logic [88:0]     tlb_w_entry,
   output logic [IDXW-1:0] tlb_r_index,
   input  logic [88:0]     tlb_r_entry,
   output logic            tlb_inv_valid,
   output logic [4:0]      tlb_inv_op
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic [2:0]      op;
   logic [4:0]      inv_op;
   logic [IDXW-1:0] idx, fill_ptr;
   logic [18:0]     vppn;
   logic [9:0]      asid;
   logic [88:0]     entry;
   logic            exec, is_srch, is_rd, is_wr, is_fill, is_inv, inv_ok;
   assign is_srch = op == 3'd0;
   assign is_rd   = op == 3'd1;
   assign is_wr   = op == 3'd2;
   assign is_fill = op == 3'd3;
   assign is_inv  = op == 3'd4;
   assign inv_ok  = is_inv && inv_op <= 5'd6;
   always_comb begin
      state_nx      = (state == IDLE && req_valid) ? EXEC :
                      (state == EXEC) ? RESP :
                      (state == RESP && resp_ready) ? IDLE : state;
      exec          = state == EXEC;
      req_ready     = state == IDLE;
      resp_valid    = state == RESP;
      tlb_we        = exec && (is_wr || is_fill);
      tlb_inv_valid = exec && inv_ok;
      mem_stall     = exec && (is_srch || inv_ok);
      tlb_s1_vppn   = mem_stall ? vppn : mem_s1_vppn;
      tlb_s1_asid   = mem_stall ? asid : mem_s1_asid;
      tlb_w_index   = idx;
      tlb_r_index   = idx;
      tlb_w_entry   = entry;
      tlb_inv_op    = inv_op;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fill_ptr   <= '0;
         op         <= '0;
         inv_op     <= '0;
         idx        <= '0;
         vppn       <= '0;
         asid       <= '0;
         entry      <= '0;
         resp_found <= 1'b0;
         resp_index <= '0;
         resp_entry <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            op     <= req_op;
            inv_op <= req_inv_op;
            idx    <= (req_op == 3'd3) ? fill_ptr : req_index;
            vppn   <= req_vppn;
            asid   <= req_asid;
            entry  <= req_entry;
         end
         if (exec) begin
            resp_found <= is_srch && tlb_s1_found;
            resp_index <= is_srch ? tlb_s1_index : is_fill ? idx : '0;
            resp_entry <= is_rd ? tlb_r_entry : '0;
            resp_err   <= op > 3'd4 || (is_inv && inv_op > 5'd6);
            if (is_fill)
               fill_ptr <= (fill_ptr == IDXW'(TLBNUM - 1)) ? '0 : fill_ptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: randomized self-checking bench with a behavioural TLB
// environment and an independent expected-contents model.
module tb_tlb_op_ctrl;
   logic        clk = 0, reset = 1;
   logic        req_valid = 0, req_ready, resp_valid, resp_ready = 0;
   logic [2:0]  req_op = 0;
   logic [4:0]  req_inv_op = 0, tlb_inv_op;
   logic [3:0]  req_index = 0, resp_index, tlb_s1_index, tlb_w_index, tlb_r_index;
   logic [18:0] req_vppn = 0, mem_s1_vppn = 0, tlb_s1_vppn;
   logic [9:0]  req_asid = 0, mem_s1_asid = 0, tlb_s1_asid;
   logic [88:0] req_entry = 0, resp_entry, tlb_w_entry, tlb_r_entry;
   logic        resp_found, resp_err, mem_stall, tlb_s1_found, tlb_we, tlb_inv_valid;
   always #5 clk = ~clk;
   tlb_op_ctrl #(.TLBNUM(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_inv_op(req_inv_op), .req_index(req_index),
      .req_vppn(req_vppn), .req_asid(req_asid), .req_entry(req_entry),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
      .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err),
      .mem_s1_vppn(mem_s1_vppn), .mem_s1_asid(mem_s1_asid), .mem_stall(mem_stall),
      .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid),
      .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
      .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
      .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op)
   );
   // behavioural TLB the controller talks to; lowest matching index wins
   logic [88:0] tlb_mem [16];
   always @(posedge clk) if (tlb_we) tlb_mem[tlb_w_index] <= tlb_w_entry;
   assign tlb_r_entry = tlb_mem[tlb_r_index];
   always_comb begin
      tlb_s1_found = 1'b0;
      tlb_s1_index = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (tlb_mem[i][88] && tlb_mem[i][87:69] == tlb_s1_vppn &&
             (tlb_mem[i][52] || tlb_mem[i][62:53] == tlb_s1_asid)) begin
            tlb_s1_found = 1'b1;
            tlb_s1_index = 4'(i);
         end
   end
   int          we_cnt = 0, inv_cnt = 0, stall_cnt = 0, mux_err = 0, both_err = 0;
   logic [3:0]  last_w_idx = 0;
   logic [4:0]  last_inv_op = 0;
   always @(negedge clk) begin
      if (tlb_we) begin we_cnt++; last_w_idx = tlb_w_index; end
      if (tlb_inv_valid) begin inv_cnt++; last_inv_op = tlb_inv_op; end
      if (mem_stall) stall_cnt++;
      if (tlb_we && tlb_inv_valid) both_err++;
      if (!mem_stall && (tlb_s1_vppn !== mem_s1_vppn || tlb_s1_asid !== mem_s1_asid)) mux_err++;
   end
   int          n_tests = 0, n_fail = 0, fill_cnt = 0;
   logic [88:0] exp_mem [16];
   logic        o_ok, o_found, o_err, e_found;
   logic [3:0]  o_index, e_index;
   logic [88:0] o_entry;
   int          o_lat, o_hold_err, d_we, d_inv, d_stall;
   function automatic logic [88:0] rnd_ent();
      logic [95:0] t = {$urandom(), $urandom(), $urandom()};
      return t[88:0];
   endfunction
   task automatic exp_search(input logic [18:0] v, input logic [9:0] a,
                             output logic f, output logic [3:0] ix);
      f = 0; ix = 0;
      for (int i = 0; i < 16; i++)
         if (!f && exp_mem[i][88] && exp_mem[i][87:69] == v &&
             (exp_mem[i][52] || exp_mem[i][62:53] == a)) begin
            f = 1; ix = 4'(i);
         end
   endtask
   task automatic run_op(input logic [2:0] op, input logic [4:0] iop, input logic [3:0] idx,
                         input logic [18:0] v, input logic [9:0] a, input logic [88:0] e,
                         input int hold);
      int we0, inv0, st0;
      logic acc, got;
      we0 = we_cnt; inv0 = inv_cnt; st0 = stall_cnt; acc = 0; got = 0; o_lat = -1;
      @(posedge clk); #1;
      req_valid = 1; req_op = op; req_inv_op = iop; req_index = idx;
      req_vppn = v; req_asid = a; req_entry = e;
      mem_s1_vppn = 19'($urandom); mem_s1_asid = 10'($urandom);
      for (int i = 0; i < 10 && !acc; i++) begin @(negedge clk); acc = req_ready; end
      @(posedge clk); #1;
      req_valid = 0;
      mem_s1_vppn = 19'($urandom); mem_s1_asid = 10'($urandom);
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = resp_valid;
         if (got) o_lat = i;
      end
      o_found = resp_found; o_index = resp_index; o_entry = resp_entry; o_err = resp_err;
      o_hold_err = 0;
      if (got && hold > 0) begin
         req_valid = 1; req_op = 3'd2;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_valid !== 1 || req_ready !== 0 || resp_found !== o_found ||
                resp_index !== o_index || resp_entry !== o_entry || resp_err !== o_err)
               o_hold_err++;
         end
      end
      @(posedge clk); #1;
      resp_ready = got; req_valid = 0;
      @(posedge clk); #1;
      resp_ready = 0;
      o_ok = acc && got;
      d_we = we_cnt - we0; d_inv = inv_cnt - inv0; d_stall = stall_cnt - st0;
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++;
      if ({resp_valid, resp_found, resp_index, resp_entry, resp_err, tlb_we, tlb_inv_valid, mem_stall} !== '0 ||
          req_ready !== 1) begin
         n_fail++;
         $display("FAIL reset: rv=%b f=%b idx=%0d err=%b we=%b inv=%b stall=%b rdy=%b, want all 0 rdy=1",
                  resp_valid, resp_found, resp_index, resp_err, tlb_we, tlb_inv_valid, mem_stall, req_ready);
      end
      @(posedge clk); #1 reset = 0;
   endtask
   task automatic test_fill();
      logic [88:0] ent;
      logic [3:0]  ei;
      for (int i = 0; i < 17; i++) begin
         ent = rnd_ent();
         ei = 4'(fill_cnt % 16);
         run_op(3'd3, 5'($urandom), 4'($urandom), 19'($urandom), 10'($urandom), ent, 0);
         exp_mem[ei] = ent;
         fill_cnt++;
         n_tests++;
         if (!o_ok || d_we != 1 || last_w_idx !== ei || o_index !== ei || o_found !== 0 || o_err !== 0 || d_stall != 0) begin
            n_fail++;
            $display("FAIL fill%0d: ok=%b we=%0d widx=%0d ridx=%0d f=%b err=%b stall=%0d, want we=1 idx=%0d f=0 err=0 stall=0",
                     i, o_ok, d_we, last_w_idx, o_index, o_found, o_err, d_stall, ei);
         end
      end
      n_tests++;
      if (o_lat != 1) begin
         n_fail++;
         $display("FAIL latency: resp_valid after %0d exec cycles, want 1", o_lat);
      end
   endtask
   task automatic test_wr_srch();
      logic [88:0] ent;
      logic [18:0] v;
      logic [9:0]  a;
      ent = rnd_ent();
      ent[88] = 1; ent[87:69] = 19'h12345; ent[62:53] = 10'h3A; ent[52] = 0;
      run_op(3'd2, 0, 4'd5, 19'($urandom), 10'($urandom), ent, 0);
      exp_mem[5] = ent;
      n_tests++;
      if (!o_ok || d_we != 1 || last_w_idx !== 4'd5 || d_stall != 0 || o_err !== 0 || o_found !== 0) begin
         n_fail++;
         $display("FAIL wr5: ok=%b we=%0d widx=%0d stall=%0d err=%b f=%b, want we=1 idx=5 stall=0 err=0 f=0",
                  o_ok, d_we, last_w_idx, d_stall, o_err, o_found);
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin v = 19'h12345; a = 10'h3A; end
         else if (i % 2 == 1) begin v = exp_mem[$urandom_range(15)][87:69]; a = 10'($urandom); end
         else begin v = 19'($urandom); a = 10'($urandom); end
         exp_search(v, a, e_found, e_index);
         run_op(3'd0, 0, 4'($urandom), v, a, rnd_ent(), 0);
         n_tests++;
         if (!o_ok || o_found !== e_found || o_index !== e_index || d_stall != 1 || d_we != 0 || o_err !== 0) begin
            n_fail++;
            $display("FAIL srch%0d: ok=%b f=%b idx=%0d stall=%0d we=%0d err=%b, want f=%b idx=%0d stall=1 we=0 err=0",
                     i, o_ok, o_found, o_index, d_stall, d_we, o_err, e_found, e_index);
         end
      end
   endtask
   task automatic test_rd();
      logic [3:0] ix;
      for (int i = 0; i < 7; i++) begin
         ix = (i == 0) ? 4'd5 : 4'($urandom);
         run_op(3'd1, 0, ix, 19'($urandom), 10'($urandom), rnd_ent(), 0);
         n_tests++;
         if (!o_ok || o_entry !== exp_mem[ix] || o_err !== 0 || o_found !== 0 || d_we != 0 || d_stall != 0) begin
            n_fail++;
            $display("FAIL rd%0d: ok=%b entry=%h err=%b f=%b we=%0d stall=%0d, want entry=%h err=0 f=0",
                     ix, o_ok, o_entry, o_err, o_found, d_we, d_stall, exp_mem[ix]);
         end
      end
   endtask
   task automatic test_inv();
      logic [2:0] ops [6] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd6, 3'd7};
      logic [4:0] iops [6] = '{5'd5, 5'd6, 5'd7, 5'd9, 5'd0, 5'd3};
      logic       legal;
      for (int i = 0; i < 6; i++) begin
         legal = ops[i] == 3'd4 && iops[i] <= 5'd6;
         run_op(ops[i], iops[i], 4'($urandom), 19'($urandom), 10'($urandom), rnd_ent(), 0);
         n_tests++;
         if (!o_ok || d_inv != int'(legal) || (legal && last_inv_op !== iops[i]) || d_stall != int'(legal) ||
             d_we != 0 || o_err !== !legal || o_found !== 0) begin
            n_fail++;
            $display("FAIL inv op=%0d iop=%0d: ok=%b inv=%0d invop=%0d stall=%0d we=%0d err=%b, want inv=%0d stall=%0d err=%b",
                     ops[i], iops[i], o_ok, d_inv, last_inv_op, d_stall, d_we, o_err, legal, legal, !legal);
         end
      end
   endtask
   task automatic test_hold();
      exp_search(19'h12345, 10'h3A, e_found, e_index);
      run_op(3'd0, 0, 0, 19'h12345, 10'h3A, rnd_ent(), 4);
      n_tests++;
      if (!o_ok || o_hold_err != 0 || d_we != 0 || o_found !== e_found || o_index !== e_index) begin
         n_fail++;
         $display("FAIL hold: ok=%b unstable=%0d we=%0d f=%b idx=%0d, want unstable=0 we=0 f=%b idx=%0d",
                  o_ok, o_hold_err, d_we, o_found, o_index, e_found, e_index);
      end
      n_tests++;
      if (mux_err != 0 || both_err != 0) begin
         n_fail++;
         $display("FAIL port_mux: mux_err=%0d both_err=%0d, want 0 0", mux_err, both_err);
      end
   endtask
   task automatic test_reset_exec();
      logic we_exec, acc;
      acc = 0;
      @(posedge clk); #1;
      req_valid = 1; req_op = 3'd2; req_index = 4'd3; req_entry = ~exp_mem[3];
      for (int i = 0; i < 10 && !acc; i++) begin @(negedge clk); acc = req_ready; end
      @(posedge clk); #1;
      req_valid = 0;
      we_exec = tlb_we;
      reset = 1;
      #1;
      n_tests++;
      if (!acc || we_exec !== 1 || tlb_we !== 0 || req_ready !== 1 || resp_valid !== 0 || mem_stall !== 0) begin
         n_fail++;
         $display("FAIL reset_exec: acc=%b we_exec=%b we=%b rdy=%b rv=%b, want 1 1 0 1 0",
                  acc, we_exec, tlb_we, req_ready, resp_valid);
      end
      @(posedge clk); #1 reset = 0;
      fill_cnt = 0;
      run_op(3'd1, 0, 4'd3, 0, 0, 0, 0);
      n_tests++;
      if (!o_ok || o_entry !== exp_mem[3]) begin
         n_fail++;
         $display("FAIL reset_nowrite: entry=%h, want %h", o_entry, exp_mem[3]);
      end
      run_op(3'd3, 0, 4'd9, 0, 0, rnd_ent(), 0);
      n_tests++;
      if (!o_ok || d_we != 1 || last_w_idx !== 4'd0 || o_index !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_fillptr: we=%0d widx=%0d ridx=%0d, want we=1 idx=0", d_we, last_w_idx, o_index);
      end
   endtask
   initial begin
      test_reset();
      test_fill();
      test_wr_srch();
      test_rd();
      test_inv();
      test_hold();
      test_reset_exec();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
